// File: rtl/instr_fetch_queue.sv
// Instruction prefetch unit: issues ROM reads ahead of the consumer into a FIFO and handles redirects.
// Define IFQ_BYPASS_EN so a returning word skips the empty queue and is presented in the same cycle.
module instr_fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ADDR_W   = 5,
  parameter int unsigned     QDEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              redir_valid,
  input  logic [XLEN-1:0]   redir_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [XLEN-1:0]   inst_data,
  output logic [XLEN-1:0]   inst_pc
);

  localparam int unsigned PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CntW = $clog2(QDEPTH + 1);

  typedef enum logic [1:0] {StBoot, StRun, StFlush} state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic                inflight_q, inflight_d;
  logic [XLEN-1:0]     inflight_pc_q, inflight_pc_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [XLEN-1:0]     qdata_q [QDEPTH];
  logic [XLEN-1:0]     qpc_q [QDEPTH];

  logic                q_empty;
  logic                bypass;
  logic                room;
  logic                push;
  logic                pop;

  assign q_empty  = (count_q == '0);
  assign mem_addr = pc_q[ADDR_W+1:2];
  // Reads in flight count against capacity so a returning word always has a slot.
  assign room     = (({1'b0, count_q} + (CntW + 1)'(inflight_q)) < (CntW + 1)'(QDEPTH));

`ifdef IFQ_BYPASS_EN
  assign bypass = q_empty && inflight_q;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    mem_en  = 1'b0;
    case (state_q)
      StBoot:  state_d = StRun;
      StRun:   mem_en  = room;
      StFlush: state_d = StRun;
      default: state_d = StBoot;
    endcase
    if (redir_valid) begin
      state_d = StFlush;
    end
  end

  always_comb begin
    inst_valid = 1'b0;
    inst_data  = '1;
    inst_pc    = '0;
    if (!q_empty) begin
      inst_valid = 1'b1;
      inst_data  = qdata_q[rd_ptr_q];
      inst_pc    = qpc_q[rd_ptr_q];
    end else if (bypass) begin
      inst_valid = 1'b1;
      inst_data  = mem_rdata;
      inst_pc    = inflight_pc_q;
    end
  end

  // A word returning in a redirect cycle belongs to the old stream and is dropped.
  assign pop  = !q_empty && inst_ready;
  assign push = inflight_q && !redir_valid && !(bypass && inst_ready);

  always_comb begin
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    // A read issued during a redirect is never marked in flight, so it is discarded on return.
    inflight_d    = mem_en && !redir_valid;
    count_d       = count_q + CntW'(push) - CntW'(pop);
    if (mem_en) begin
      pc_d          = pc_q + XLEN'(4);
      inflight_pc_d = pc_q;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (redir_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      pc_d     = redir_pc & ~XLEN'(3);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StBoot;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      qdata_q[wr_ptr_q] <= mem_rdata;
      qpc_q[wr_ptr_q]   <= inflight_pc_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios plus random ready/redirect traffic checked
// against an in-order instruction-stream model. Honours IFQ_BYPASS_EN for the latency check.
module tb_instr_fetch_queue;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned QDEPTH   = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef IFQ_BYPASS_EN
  localparam int FirstValidK = 2;
`else
  localparam int FirstValidK = 3;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_rdata = '0;
  logic              redir_valid = 1'b0;
  logic [XLEN-1:0]   redir_pc = '0;
  logic              inst_valid;
  logic              inst_ready = 1'b0;
  logic [XLEN-1:0]   inst_data;
  logic [XLEN-1:0]   inst_pc;

  instr_fetch_queue #(
    .XLEN     (XLEN),
    .ADDR_W   (ADDR_W),
    .QDEPTH   (QDEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_en      (mem_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc)
  );

  always #5 clk = ~clk;

  // ROM with one-cycle read latency; word n holds 0x1000_0000 + n.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= 32'h1000_0000 + 32'(mem_addr);
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;
  logic        hold = 1'b0;
  logic [31:0] hold_data, hold_pc;
  logic        need_cont = 1'b0;
  logic        seen_valid;
  logic [31:0] seen_pc;
  int          n_acc = 0;

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    return 32'h1000_0000 + {27'b0, pc[6:2]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Stream model: accepted words follow exp_pc, which restarts at each redirect target.
  task automatic observe(input logic rv);
    seen_valid = inst_valid;
    seen_pc    = inst_pc;
    if (!inst_valid) begin
      chk("idle_data", inst_data, 32'hFFFF_FFFF);
      chk("idle_pc", inst_pc, 32'h0);
    end
    if (hold) begin
      chk("hold_valid", 32'(inst_valid), 32'd1);
      chk("hold_data", inst_data, hold_data);
      chk("hold_pc", inst_pc, hold_pc);
    end
    if (need_cont) chk("no_gap", 32'(inst_valid), 32'd1);
    if (inst_valid && inst_ready) begin
      chk("stream_pc", inst_pc, exp_pc);
      chk("stream_data", inst_data, rom_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      n_acc++;
    end
    hold      = inst_valid && !inst_ready && !rv;
    hold_data = inst_data;
    hold_pc   = inst_pc;
    if (rv) exp_pc = redir_pc & 32'hFFFF_FFFC;
  endtask

  // Called at a falling edge; drives inputs, checks, then returns at the next falling edge.
  task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
    inst_ready  = rdy;
    redir_valid = rv;
    redir_pc    = rpc;
    #1;
    observe(rv);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int          first_k;
    int          n0;
    logic        found;
    logic [31:0] first_pc;
    logic [31:0] fa;

    exp_pc = RESET_PC;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_data", inst_data, 32'hFFFF_FFFF);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'(RESET_PC[6:2]));

    // Fill latency and gap-free streaming from RESET_PC.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("boot_mem_en", 32'(mem_en), 32'd0);
    first_k = -1;
    cycle(1'b1, 1'b0, 32'h0);
    chk("run_mem_en", 32'(mem_en), 32'd1);
    for (int k = 1; k < 6; k++) begin
      cycle(1'b1, 1'b0, 32'h0);
      if (first_k < 0 && seen_valid) first_k = k;
    end
    chk("first_valid_latency", 32'(first_k), 32'(FirstValidK));
    need_cont = 1'b1;
    repeat (20) cycle(1'b1, 1'b0, 32'h0);
    need_cont = 1'b0;

    // Asynchronous reset mid-stream.
    #2;
    chk("pre_reset_valid", 32'(inst_valid), 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_valid", 32'(inst_valid), 32'd0);
    chk("midrst_data", inst_data, 32'hFFFF_FFFF);
    chk("midrst_pc", inst_pc, 32'h0);
    chk("midrst_mem_en", 32'(mem_en), 32'd0);
    chk("midrst_addr", 32'(mem_addr), 32'(RESET_PC[6:2]));
    hold   = 1'b0;
    exp_pc = RESET_PC;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Stalled consumer: exactly QDEPTH words buffered, then fetch stops.
    repeat (12) cycle(1'b0, 1'b0, 32'h0);
    fa = (exp_pc + 32'(4 * QDEPTH)) >> 2;
    chk("full_mem_en", 32'(mem_en), 32'd0);
    chk("full_fetch_addr", 32'(mem_addr), {27'b0, fa[4:0]});
    n0 = n_acc;
    need_cont = 1'b1;
    repeat (12) cycle(1'b1, 1'b0, 32'h0);
    need_cont = 1'b0;
    chk("drain_count", 32'(n_acc - n0), 32'd12);

    // Redirect with a backed-up queue and a read in flight.
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h40);
    cycle(1'b1, 1'b0, 32'h0);
    chk("flush_valid", 32'(seen_valid), 32'd0);
    found    = 1'b0;
    first_pc = 32'h0;
    for (int i = 0; i < 8 && !found; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      if (seen_valid) begin
        found    = 1'b1;
        first_pc = seen_pc;
      end
    end
    chk("redir_found", 32'(found), 32'd1);
    chk("redir_first_pc", first_pc, 32'h40);
    repeat (4) cycle(1'b1, 1'b0, 32'h0);

    // Unaligned target and ROM address wrap past 0x7C.
    cycle(1'b1, 1'b1, 32'h7E);
    n0 = n_acc;
    repeat (8) cycle(1'b1, 1'b0, 32'h0);
    chk("wrap_progress", 32'(n_acc - n0 >= 5), 32'd1);

    // Random backpressure and redirects.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom % 4) != 0, ($urandom % 16) == 0, $urandom);
    end
    n0 = n_acc;
    repeat (10) cycle(1'b1, 1'b0, 32'h0);
    chk("final_progress", 32'(n_acc - n0 >= 5), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter XLEN, 32, instruction and PC width in bits.
REQ-002 Parameter ADDR_W, 5, instruction-ROM word-address width.
REQ-003 Parameter QDEPTH, 4, prefetch queue entries; power of two, >=2.
REQ-004 Parameter RESET_PC, 0, first fetch address after reset.
REQ-005 clk  in  1  clock; all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 mem_en  out  1  ROM read enable; one read issued per asserted cycle.
REQ-008 mem_addr  out  ADDR_W  ROM word address, = fetch PC[ADDR_W+1:2].
REQ-009 mem_rdata  in  XLEN  ROM data; valid exactly one cycle after mem_en.
REQ-010 redir_valid  in  1  redirect request (branch/jump), single-cycle pulse.
REQ-011 redir_pc  in  XLEN  redirect target byte address.
REQ-012 inst_valid  out  1  inst_data/inst_pc hold a fetched instruction.
REQ-013 inst_ready  in  1  consumer accepts; transfer when valid&&ready.
REQ-014 inst_data  out  XLEN  instruction word.
REQ-015 inst_pc  out  XLEN  byte address of inst_data.

Function
REQ-016 FSM states: BOOT, RUN, FLUSH; BOOT->RUN after one cycle; RUN->FLUSH on redir_valid; FLUSH->RUN after one cycle.
REQ-017 BOOT: mem_en=0, fetch PC=RESET_PC; no handshake.
REQ-018 RUN: mem_en=1 iff (queue count + in-flight reads) < QDEPTH; fetch PC += 4 on each issue.
REQ-019 ROM latency 1 cycle: data returned is written to the queue tail with its PC at the following edge.
REQ-020 Queue is FIFO, pointer wrap modulo QDEPTH; count range 0..QDEPTH; never overflows (REQ-018 guarantees room).
REQ-021 Simultaneous push and pop: both occur, count unchanged; pop from full queue same cycle as push allowed.
REQ-022 inst_valid=0 when queue empty (subject to REQ-034); inst_data=all-ones and inst_pc=0 while inst_valid=0.
REQ-023 Outputs stable while inst_valid&&!inst_ready.
REQ-024 Redirect: queue flushed at next edge, any in-flight read marked stale and discarded on return, fetch PC <= {redir_pc[XLEN-1:2],2'b00}; redir_pc[1:0] ignored.
REQ-025 FLUSH: mem_en=0, inst_valid=0; first issue of new PC in the cycle after FLUSH.
REQ-026 Redirect with handshake same cycle: current transfer completes, then flush.
REQ-027 redir_valid while in FLUSH or BOOT: new target overwrites fetch PC; FSM enters/stays FLUSH one further cycle.
REQ-028 Fetch PC wraps modulo 2^XLEN; mem_addr wraps modulo 2^ADDR_W.

Reset
REQ-029 rst low asynchronously: FSM=BOOT, queue empty, in-flight cleared, fetch PC=RESET_PC.
REQ-030 During reset: mem_en=0, inst_valid=0, inst_data=all-ones, inst_pc=0, mem_addr=RESET_PC[ADDR_W+1:2].
REQ-031 Reset mid-operation discards all queued and in-flight data; no stale word is presented after release.
REQ-032 Reset release synchronous to clk; first mem_en no earlier than second rising edge after release.

Configuration
REQ-033 Macro IFQ_BYPASS_EN selects empty-queue bypass.
REQ-034 Defined: when queue empty and a non-stale read returns, mem_rdata and its PC drive outputs combinationally with inst_valid=1 that cycle; written to queue only if not accepted.
REQ-035 Undefined: returned data always enters queue; earliest inst_valid is the cycle after return (issue-to-valid latency 2 cycles vs 1).

Verification
REQ-036 Reset release, ROM word n = 0x1000_0000+n, inst_ready=1 -> inst_pc 0,4,8,... with matching data, one per cycle after pipeline fill, no gaps.
REQ-037 inst_ready=0 for 10 cycles -> exactly QDEPTH entries buffered, mem_en deasserts, no overflow; release -> in-order 0x0..0xC then continuous.
REQ-038 redir_valid with redir_pc=0x40 while queue full and read in flight -> no word from old stream appears; next inst_pc=0x40, data=ROM[16].
REQ-039 redir_pc=0x7E (ADDR_W=5) -> inst_pc 0x7C, then 0x80 with mem_addr wrapped to 0.
REQ-040 rst asserted mid-stream with inst_valid=1 -> outputs to reset values same cycle; after release stream restarts at RESET_PC.
REQ-041 Run REQ-036 with and without IFQ_BYPASS_EN -> first inst_valid one cycle earlier with macro defined; identical data sequence.
